// File: rtl/qla_ioexp_ctrl.sv
// SPI I/O-expander controller for QLA motor channels: probes the expander, writes
// cur_ctrl/amp_disable_f to the output port, reads it back and flags per-channel mismatches.
module qla_ioexp_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int SCLK_DIV    = 8,
    parameter int REFRESH_CYC = 49152
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] cur_ctrl,
    input  logic [NUM_CH-1:0] amp_disable_f,
    output logic              ioexp_present,
    output logic [NUM_CH-1:0] cur_ctrl_error,
    output logic [NUM_CH-1:0] disable_f_error,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int PW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int RW = $clog2(REFRESH_CYC + 1);

    localparam logic [2:0] PROBE_WR  = 3'd0;
    localparam logic [2:0] PROBE_RD  = 3'd1;
    localparam logic [2:0] ABSENT    = 3'd2;
    localparam logic [2:0] IDLE      = 3'd3;
    localparam logic [2:0] WRITE_OUT = 3'd4;
    localparam logic [2:0] READ_BACK = 3'd5;
    localparam logic [2:0] CHECK     = 3'd6;

    localparam logic [6:0] REG_OUT     = 7'h02;
    localparam logic [6:0] REG_SCRATCH = 7'h07;
    localparam logic [7:0] PROBE_PAT   = 8'hA5;

    logic [2:0]    state, state_nx;
    logic [PW-1:0] ph;
    logic [5:0]    half, half_nx;
    logic [15:0]   tx;
    logic [7:0]    rx;
    logic [7:0]    req, snap, last;
    logic          last_valid;
    logic [RW-1:0] refresh;
    logic          half_end, frame_end, rise_cyc, launch;
    logic [15:0]   launch_word;

    // A frame is 34 half-periods: 32 carry SCLK, the last 2 are the CS-high gap.
    always_comb begin
        req = '0;
        req[NUM_CH-1:0] = cur_ctrl;
        req[4 +: NUM_CH] = amp_disable_f;

        half_nx   = half + 6'd1;
        half_end  = busy && (ph == PW'(SCLK_DIV - 1));
        frame_end = half_end && (half == 6'd33);
        rise_cyc  = busy && half[0] && (half < 6'd32) && (ph == '0);

        launch      = 1'b0;
        launch_word = '0;
        state_nx    = state;
        case (state)
            PROBE_WR: begin
                if (!busy) begin
                    launch      = 1'b1;
                    launch_word = {1'b0, REG_SCRATCH, PROBE_PAT};
                end else if (frame_end) begin
                    launch      = 1'b1;
                    launch_word = {1'b1, REG_SCRATCH, 8'h00};
                    state_nx    = PROBE_RD;
                end
            end
            PROBE_RD: begin
                if (frame_end) state_nx = (rx == PROBE_PAT) ? IDLE : ABSENT;
            end
            IDLE: begin
                if (!last_valid || (req != last) || (refresh == '0)) begin
                    launch      = 1'b1;
                    launch_word = {1'b0, REG_OUT, req};
                    state_nx    = WRITE_OUT;
                end
            end
            WRITE_OUT: begin
                if (frame_end) begin
                    launch      = 1'b1;
                    launch_word = {1'b1, REG_OUT, 8'h00};
                    state_nx    = READ_BACK;
                end
            end
            READ_BACK: begin
                if (frame_end) state_nx = CHECK;
            end
            CHECK:   state_nx = IDLE;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= PROBE_WR;
            busy            <= 1'b0;
            ph              <= '0;
            half            <= '0;
            spi_cs_n        <= 1'b1;
            spi_sclk        <= 1'b0;
            spi_mosi        <= 1'b0;
            ioexp_present   <= 1'b0;
            cur_ctrl_error  <= '0;
            disable_f_error <= '0;
            last_valid      <= 1'b0;
            refresh         <= RW'(REFRESH_CYC);
        end else begin
            state <= state_nx;

            if (launch) begin
                busy     <= 1'b1;
                ph       <= '0;
                half     <= '0;
                spi_cs_n <= 1'b0;
                spi_sclk <= 1'b0;
                spi_mosi <= launch_word[15];
            end else if (frame_end) begin
                busy <= 1'b0;
            end else if (half_end) begin
                ph   <= '0;
                half <= half_nx;
                if (half_nx < 6'd32) begin
                    spi_sclk <= half_nx[0];
                    if (!half_nx[0]) spi_mosi <= tx[15];
                end else if (half_nx == 6'd32) begin
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b0;
                    spi_mosi <= 1'b0;
                end
            end else if (busy) begin
                ph <= ph + PW'(1);
            end

            if (state == PROBE_RD && frame_end && rx == PROBE_PAT) ioexp_present <= 1'b1;

            // Error flags are rewritten on every check so a clean readback clears them.
            if (state == CHECK) begin
                cur_ctrl_error  <= rx[NUM_CH-1:0] ^ snap[NUM_CH-1:0];
                disable_f_error <= rx[4 +: NUM_CH] ^ snap[4 +: NUM_CH];
                last_valid      <= 1'b1;
                refresh         <= RW'(REFRESH_CYC);
            end else if (state == IDLE && !launch && refresh != '0) begin
                refresh <= refresh - RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            tx <= {launch_word[14:0], 1'b0};
        end else if (half_end && !frame_end && (half_nx < 6'd32) && !half_nx[0]) begin
            tx <= {tx[14:0], 1'b0};
        end
        if (rise_cyc) rx <= {rx[6:0], spi_miso};
        if (state == IDLE && launch) snap <= req;
        if (state == CHECK) last <= snap;
    end

endmodule
